// File: rtl/score_display.sv
// score_display: turns the processor's signed 32-bit score into a multiplexed,
// active-low, 8-digit seven-segment display.
//
// A captured score is clamped to 0..SAT_MAX and converted to BCD by a
// bit-serial double-dabble engine. The displayed BCD is only replaced once a
// conversion has finished, so partial results never reach the display.
//
// Ports:
//   clock  - master clock (processor domain)
//   reset  - synchronous, active-high reset
//   score  - signed score from the processor
//   seg    - segments {g,f,e,d,c,b,a}, active-low, registered
//   an     - digit anodes, an[0] = least-significant digit, active-low, registered
//   dp     - decimal point, active-low, always off
//   busy   - high while a conversion is in progress
module score_display #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned SAT_MAX     = 99999999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] score,
   output logic [6:0]  seg,
   output logic [7:0]  an,
   output logic        dp,
   output logic        busy
);

   localparam int unsigned RefW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {StIdle, StClamp, StShift, StDone} state_e;

   state_e         state_q;
   logic [31:0]    cap_q;
   logic [26:0]    bin_q;
   logic [31:0]    bcd_q;
   logic [31:0]    disp_q;
   logic [4:0]     iter_q;
   logic [RefW-1:0] ref_q;
   logic [2:0]     idx_q;

   logic [31:0]    bcd_adj;
   logic [26:0]    clamped;
   logic [31:0]    digit_sel;
   logic [3:0]     nibble;
   logic           blank;
   logic [6:0]     seg_dec;

   // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 8; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Negative scores show 0; anything beyond SAT_MAX saturates.
   always_comb begin
      if (cap_q[31]) begin
         clamped = '0;
      end else if (cap_q > SAT_MAX) begin
         clamped = 27'(SAT_MAX);
      end else begin
         clamped = cap_q[26:0];
      end
   end

   // Digits at and above the scanned one; all zero means a leading zero.
   always_comb begin
      digit_sel = disp_q >> {idx_q, 2'b00};
      nibble    = digit_sel[3:0];
      blank     = (idx_q != 3'd0) && (digit_sel == 32'd0);
   end

   always_comb begin
      case (nibble)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'h7F;
      endcase
   end

   // Capture / convert FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cap_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         disp_q  <= '0;
         iter_q  <= '0;
         busy    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (score != cap_q) begin
                  cap_q   <= score;
                  busy    <= 1'b1;
                  state_q <= StClamp;
               end
            end
            StClamp: begin
               bin_q   <= clamped;
               bcd_q   <= '0;
               iter_q  <= 5'd27;
               state_q <= StShift;
            end
            StShift: begin
               bcd_q  <= {bcd_adj[30:0], bin_q[26]};
               bin_q  <= {bin_q[25:0], 1'b0};
               iter_q <= iter_q - 5'd1;
               // Last shift is the one that takes the counter to zero.
               if (iter_q == 5'd1) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               disp_q  <= bcd_q;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Digit scan; an and seg both lag idx_q by one register stage.
   always_ff @(posedge clock) begin
      if (reset) begin
         ref_q <= '0;
         idx_q <= '0;
         an    <= 8'hFF;
         seg   <= 7'h7F;
      end else begin
         if (ref_q == RefLast) begin
            ref_q <= '0;
            idx_q <= idx_q + 3'd1;
         end else begin
            ref_q <= ref_q + 1'b1;
         end
         an  <= ~(8'd1 << idx_q);
         seg <= blank ? 7'h7F : seg_dec;
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] score = '0;

   logic [6:0]  seg1, seg2;
   logic [7:0]  an1, an2;
   logic        dp1, dp2, busy1, busy2;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [31:0] cur_score = '0;

   score_display #(.REFRESH_DIV(4), .SAT_MAX(99999999)) u_dut (
      .clock (clock),
      .reset (reset),
      .score (score),
      .seg   (seg1),
      .an    (an1),
      .dp    (dp1),
      .busy  (busy1)
   );

   score_display #(.REFRESH_DIV(2), .SAT_MAX(99999999)) u_fast (
      .clock (clock),
      .reset (reset),
      .score (score),
      .seg   (seg2),
      .an    (an2),
      .dp    (dp2),
      .busy  (busy2)
   );

   always #5 clock = ~clock;

   // Reference: value the display should show for a raw score.
   function automatic longint model_value(logic [31:0] s);
      if (s[31]) return 0;
      if (s > 32'd99999999) return 99999999;
      return longint'(s);
   endfunction

   // Reference: seven-segment pattern expected on digit i for value v.
   function automatic logic [6:0] model_seg(longint v, int i);
      logic [6:0] enc [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      longint p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      if (i > 0 && v < p) return 7'h7F;
      return enc[int'((v / p) % 10)];
   endfunction

   task automatic check_display(string name, longint v, bit fast);
      logic [6:0] seen [8];
      bit         got  [8];
      int         ncyc;
      logic [7:0] a;
      logic [6:0] s;
      ncyc = fast ? 20 : 40;
      for (int i = 0; i < 8; i++) begin
         got[i]  = 1'b0;
         seen[i] = 7'h7F;
      end
      repeat (2) @(negedge clock);
      for (int c = 0; c < ncyc; c++) begin
         a = fast ? an2 : an1;
         s = fast ? seg2 : seg1;
         tests++;
         if ($countones(~a) != 1) begin
            fails++;
            $display("FAIL %s_onehot: an=%h, required exactly one low bit", name, a);
         end else begin
            for (int i = 0; i < 8; i++) begin
               if (!a[i]) begin
                  seen[i] = s;
                  got[i]  = 1'b1;
               end
            end
         end
         @(negedge clock);
      end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (!got[i] || seen[i] !== model_seg(v, i)) begin
            fails++;
            $display("FAIL %s_digit%0d: seg=%h (scanned=%0d), required %h for value %0d",
                     name, i, seen[i], got[i], model_seg(v, i), v);
         end
      end
   endtask

   task automatic wait_busy_rise(string name);
      bit seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         @(negedge clock);
         if (busy1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_busy_rise: busy=0 after 4 cycles, required 1", name);
      end
   endtask

   task automatic wait_busy_low(string name);
      bit low = 1'b0;
      for (int k = 0; k < 100 && !low; k++) begin
         @(negedge clock);
         if (!busy1) low = 1'b1;
      end
      tests++;
      if (!low) begin
         fails++;
         $display("FAIL %s_busy_fall: busy=1 after 100 cycles, required 0", name);
      end
   endtask

   // Drive a new score, check busy lasts 29 cycles, then check the display.
   task automatic do_conversion(string name, logic [31:0] s);
      int unsigned n = 0;
      bit          seen = 1'b0;
      score     = s;
      cur_score = s;
      for (int k = 0; k < 4 && !seen; k++) begin
         @(negedge clock);
         if (busy1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_busy_rise: busy=0 after 4 cycles, required 1", name);
      end else begin
         n = 1;
         while (n < 100) begin
            @(negedge clock);
            if (!busy1) break;
            n++;
         end
         tests++;
         if (n != 29) begin
            fails++;
            $display("FAIL %s_busy_len: busy high %0d cycles, required 29", name, n);
         end
      end
      check_display(name, model_value(s), 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      score = '0;
      cur_score = '0;
      repeat (3) @(negedge clock);
      tests++;
      if (an1 !== 8'hFF || an2 !== 8'hFF) begin
         fails++;
         $display("FAIL reset_an: an=%h/%h, required ff", an1, an2);
      end
      tests++;
      if (seg1 !== 7'h7F) begin
         fails++;
         $display("FAIL reset_seg: seg=%h, required 7f", seg1);
      end
      tests++;
      if (busy1 !== 1'b0 || dp1 !== 1'b1) begin
         fails++;
         $display("FAIL reset_busy_dp: busy=%b dp=%b, required 0/1", busy1, dp1);
      end
      reset = 1'b0;
      @(negedge clock);
      tests++;
      if (an1 !== 8'hFE) begin
         fails++;
         $display("FAIL reset_first_anode: an=%h, required fe", an1);
      end
      check_display("reset_zero", 0, 1'b0);
   endtask

   task automatic test_saturate;
      do_conversion("conv_1234", 32'd1234);
      do_conversion("sat_150m", 32'd150000000);
      do_conversion("neg_10", 32'hFFFF_FFF6);
      do_conversion("exact_max", 32'd99999999);
      do_conversion("max_plus1", 32'd100000000);
   endtask

   task automatic test_random;
      logic [31:0] s;
      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 3) == 0) s = $urandom;
         else s = $urandom_range(0, 99999999);
         if (s == cur_score) s = s + 32'd1;
         do_conversion("random", s);
      end
   endtask

   task automatic test_mid_change;
      score     = 32'd5;
      cur_score = 32'd5;
      wait_busy_rise("mid");
      repeat (11) @(negedge clock);
      score     = 32'd77;
      cur_score = 32'd77;
      wait_busy_low("mid_first");
      check_display("mid_first", 5, 1'b1);
      tests++;
      if (busy1 !== 1'b1) begin
         fails++;
         $display("FAIL mid_restart: busy=%b, required 1", busy1);
      end
      wait_busy_low("mid_second");
      check_display("mid_second", 77, 1'b0);
   endtask

   task automatic test_reset_mid;
      score     = 32'd4321;
      cur_score = 32'd4321;
      wait_busy_rise("rstmid");
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      tests++;
      if (busy1 !== 1'b0 || an1 !== 8'hFF) begin
         fails++;
         $display("FAIL rstmid_abort: busy=%b an=%h, required 0/ff", busy1, an1);
      end
      reset = 1'b0;
      check_display("rstmid_zero", 0, 1'b1);
      tests++;
      if (busy1 !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_recapture: busy=%b, required 1", busy1);
      end
      wait_busy_low("rstmid");
      check_display("rstmid_final", 4321, 1'b0);
   endtask

   task automatic test_scan;
      logic [7:0] prev;
      logic [7:0] expv;
      bit         found = 1'b0;
      prev = an2;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clock);
         if (an2 == 8'hFE && prev != 8'hFE) found = 1'b1;
         else prev = an2;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL scan_sync: no fe entry within 40 cycles, last an=%h", an2);
      end else begin
         for (int k = 0; k < 32; k++) begin
            expv = ~(8'd1 << ((k / 2) % 8));
            tests++;
            if (an2 !== expv) begin
               fails++;
               $display("FAIL scan_step%0d: an=%h, required %h", k, an2, expv);
            end
            @(negedge clock);
         end
      end
   endtask

   initial begin
      test_reset();
      test_saturate();
      test_random();
      test_mid_change();
      test_reset_mid();
      test_scan();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
